// File: rtl/pkt_ctl_pkg.sv
// Control-word layout shared by the c8to512 packer and the c512to8 serializer.
// Both ends must agree on these bit positions.
package pkt_ctl_pkg;

   localparam int DATA_WIDTH_DEF = 480;
   localparam int CTRL_WIDTH_DEF = 32;

   localparam int CTL_SOP_BIT = 31;
   localparam int CTL_EOP_BIT = 30;
   localparam int CTL_CNT_LSB = 0;
   localparam int CTL_CNT_W   = 6;

   // IDLE: no packet open; SHIFT: a packet is open and expects a continuation word
   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_SHIFT = 1'b1
   } ser_state_e;

   function automatic logic cnt_invalid(input logic [CTL_CNT_W-1:0] cnt,
                                        input logic [CTL_CNT_W-1:0] max_cnt);
      return (cnt == '0) || (cnt > max_cnt);
   endfunction

endpackage

// File: rtl/c512to8_shifter.sv
// Loadable byte shifter: presents the top byte of a wide word and walks through
// cnt bytes, with registered first/last/eop flags for the current byte.
module c512to8_shifter #(
   parameter int DATA_WIDTH = 480,
   parameter int CNT_W      = 6
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  load_i,
   input  logic [DATA_WIDTH-1:0] load_data_i,
   input  logic [CNT_W-1:0]      load_cnt_i,
   input  logic                  load_sop_i,
   input  logic                  load_eop_i,
   input  logic                  adv_i,
   output logic [7:0]            byte_o,
   output logic                  valid_o,
   output logic                  last_o,
   output logic                  newpkt_o,
   output logic                  eop_o
);

   logic [DATA_WIDTH-1:0] data_q;
   logic [CNT_W-1:0]      idx_q, cnt_q;
   logic                  valid_q, last_q, newpkt_q, weop_q, eop_q;
   logic                  next_last;

   // Byte idx+1 becomes current after an advance; it is the last when idx+2 == cnt.
   assign next_last = (({1'b0, idx_q} + (CNT_W+1)'(2)) == {1'b0, cnt_q});

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         data_q   <= '0;
         idx_q    <= '0;
         cnt_q    <= '0;
         valid_q  <= 1'b0;
         last_q   <= 1'b0;
         newpkt_q <= 1'b0;
         weop_q   <= 1'b0;
         eop_q    <= 1'b0;
      end else if (load_i) begin
         data_q   <= load_data_i;
         idx_q    <= '0;
         cnt_q    <= load_cnt_i;
         valid_q  <= 1'b1;
         last_q   <= (load_cnt_i == CNT_W'(1));
         newpkt_q <= load_sop_i;
         weop_q   <= load_eop_i;
         eop_q    <= load_eop_i && (load_cnt_i == CNT_W'(1));
      end else if (adv_i && valid_q) begin
         newpkt_q <= 1'b0;
         if (last_q) begin
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            eop_q   <= 1'b0;
         end else begin
            data_q <= {data_q[DATA_WIDTH-9:0], 8'h00};
            idx_q  <= idx_q + CNT_W'(1);
            last_q <= next_last;
            eop_q  <= weop_q && next_last;
         end
      end
   end

   assign byte_o   = data_q[DATA_WIDTH-1 -: 8];
   assign valid_o  = valid_q;
   assign last_o   = last_q;
   assign newpkt_o = newpkt_q;
   assign eop_o    = eop_q;

endmodule

// File: rtl/c512to8.sv
// Wide-to-byte serializer: one holding register feeds a byte shifter so output
// stays gapless across word and packet boundaries.
module c512to8
   import pkt_ctl_pkg::*;
#(
   parameter int DATA_WIDTH = DATA_WIDTH_DEF,
   parameter int CTRL_WIDTH = CTRL_WIDTH_DEF
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_wr,
   input  logic [CTRL_WIDTH-1:0] in_ctl,
   input  logic [DATA_WIDTH-1:0] in_data,
   output logic                  in_rdy,
   input  logic                  pause,
   output logic [7:0]            out_data,
   output logic                  out_valid,
   output logic                  out_newpkt,
   output logic                  out_eop,
   output logic [7:0]            pktcount,
   output logic                  err
);

   localparam int                   BYTES   = DATA_WIDTH / 8;
   localparam logic [CTL_CNT_W-1:0] BYTES_C = CTL_CNT_W'(BYTES);

   logic                  hold_full_q, hold_full_d, in_rdy_q;
   logic [DATA_WIDTH-1:0] hold_data_q;
   logic                  hold_sop_q, hold_eop_q;
   logic [CTL_CNT_W-1:0]  hold_cnt_q;
   ser_state_e            state_q, state_d;
   logic [7:0]            pktcount_q, pktcount_d;
   logic                  err_q, err_d;

   logic                  sh_valid, sh_last, sh_newpkt, sh_eop;
   logic [7:0]            sh_byte;
   logic                  consume, sh_free, accept, take, drop, load, hold_ld;
   logic [DATA_WIDTH-1:0] cand_data;
   logic                  cand_sop, cand_eop, cnt_bad;
   logic [CTL_CNT_W-1:0]  cand_cnt, cand_len;
   logic                  unused_ctl;

   assign unused_ctl = ^in_ctl[CTL_EOP_BIT-1:CTL_CNT_LSB+CTL_CNT_W];

   assign consume = sh_valid && !pause;
   assign sh_free = !sh_valid || (sh_last && consume);
   assign accept  = in_wr && in_rdy_q;

   // The held word always goes first; an empty hold lets the input pass straight through.
   assign cand_data = hold_full_q ? hold_data_q : in_data;
   assign cand_sop  = hold_full_q ? hold_sop_q  : in_ctl[CTL_SOP_BIT];
   assign cand_eop  = hold_full_q ? hold_eop_q  : in_ctl[CTL_EOP_BIT];
   assign cand_cnt  = hold_full_q ? hold_cnt_q  : in_ctl[CTL_CNT_LSB +: CTL_CNT_W];
   assign cnt_bad   = cnt_invalid(cand_cnt, BYTES_C);
   assign cand_len  = cnt_bad ? BYTES_C : cand_cnt;

   assign take    = sh_free && (hold_full_q || accept);
   assign drop    = take && (state_q == ST_IDLE) && !cand_sop;
   assign load    = take && !drop;
   assign hold_ld = accept && !take;

   assign hold_full_d = hold_full_q ? !take : hold_ld;
   assign state_d     = load ? (cand_eop ? ST_IDLE : ST_SHIFT) : state_q;
   assign err_d       = err_q | (take && cnt_bad) | drop
                      | (load && (state_q == ST_SHIFT) && cand_sop);
   assign pktcount_d  = pktcount_q + {7'd0, consume && sh_eop};

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         hold_full_q <= 1'b0;
         in_rdy_q    <= 1'b0;
         hold_data_q <= '0;
         hold_sop_q  <= 1'b0;
         hold_eop_q  <= 1'b0;
         hold_cnt_q  <= '0;
         state_q     <= ST_IDLE;
         pktcount_q  <= '0;
         err_q       <= 1'b0;
      end else begin
         hold_full_q <= hold_full_d;
         in_rdy_q    <= !hold_full_d;
         if (hold_ld) begin
            hold_data_q <= in_data;
            hold_sop_q  <= in_ctl[CTL_SOP_BIT];
            hold_eop_q  <= in_ctl[CTL_EOP_BIT];
            hold_cnt_q  <= in_ctl[CTL_CNT_LSB +: CTL_CNT_W];
         end
         state_q    <= state_d;
         pktcount_q <= pktcount_d;
         err_q      <= err_d;
      end
   end

   c512to8_shifter #(
      .DATA_WIDTH (DATA_WIDTH),
      .CNT_W      (CTL_CNT_W)
   ) u_shifter (
      .clk         (clk),
      .rst         (rst),
      .load_i      (load),
      .load_data_i (cand_data),
      .load_cnt_i  (cand_len),
      .load_sop_i  (cand_sop),
      .load_eop_i  (cand_eop),
      .adv_i       (consume),
      .byte_o      (sh_byte),
      .valid_o     (sh_valid),
      .last_o      (sh_last),
      .newpkt_o    (sh_newpkt),
      .eop_o       (sh_eop)
   );

   assign in_rdy     = in_rdy_q;
   assign out_data   = sh_byte;
   assign out_valid  = sh_valid;
   assign out_newpkt = sh_newpkt;
   assign out_eop    = sh_eop;
   assign pktcount   = pktcount_q;
   assign err        = err_q;

endmodule

// File: tb/tb_c512to8.sv
// Scoreboard bench for c512to8: words are expanded into expected bytes by a
// packet-level model; a monitor pops and compares every consumed byte.
module tb_c512to8;

   localparam int DW = 480;
   localparam int CW = 32;
   localparam int NB = DW / 8;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          in_wr = 1'b0;
   logic [CW-1:0] in_ctl = '0;
   logic [DW-1:0] in_data = '0;
   logic          pause = 1'b0;
   logic          in_rdy, out_valid, out_newpkt, out_eop, err;
   logic [7:0]    out_data, pktcount;

   c512to8 #(.DATA_WIDTH(DW), .CTRL_WIDTH(CW)) dut (
      .clk        (clk),
      .rst        (rst),
      .in_wr      (in_wr),
      .in_ctl     (in_ctl),
      .in_data    (in_data),
      .in_rdy     (in_rdy),
      .pause      (pause),
      .out_data   (out_data),
      .out_valid  (out_valid),
      .out_newpkt (out_newpkt),
      .out_eop    (out_eop),
      .pktcount   (pktcount),
      .err        (err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [7:0] d;
      logic       sop;
      logic       eop;
   } exp_t;

   exp_t       exp_q[$];
   int         errors = 0;
   int         checks = 0;
   bit         m_open = 0;
   bit         m_err = 0;
   logic [7:0] m_pkts = 8'd0;
   int         pops = 0;
   int         cyc = 0;
   int         last_pop_cyc = 0;
   int         prev_pop_cyc = 0;
   int         pmode = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, expv, $time);
      end
   endtask

   // Packet-level model: a word either opens/continues a packet or is dropped.
   function automatic void model_word(input bit sop, input bit eop, input logic [5:0] c,
                                      input logic [DW-1:0] d);
      int n;
      exp_t e;
      n = (c == 0 || c > NB) ? NB : int'(c);
      if (c == 0 || c > NB) m_err = 1;
      if (!m_open && !sop) begin
         m_err = 1;
         return;
      end
      if (m_open && sop) m_err = 1;
      for (int k = 0; k < n; k++) begin
         e.d   = d[DW-1-8*k -: 8];
         e.sop = (k == 0) && sop;
         e.eop = (k == n-1) && eop;
         exp_q.push_back(e);
      end
      m_open = !eop;
      if (eop) m_pkts = m_pkts + 8'd1;
   endfunction

   function automatic logic [DW-1:0] rand_word();
      logic [DW-1:0] w;
      for (int i = 0; i < DW/32; i++) w[i*32 +: 32] = $urandom;
      return w;
   endfunction

   // Called at posedge+1; returns at posedge+1 after the transfer edge.
   task automatic send_word(input bit sop, input bit eop, input logic [5:0] c,
                            input logic [DW-1:0] d);
      bit ok = 0;
      in_ctl     = '0;
      in_ctl[31] = sop;
      in_ctl[30] = eop;
      in_ctl[5:0] = c;
      in_data    = d;
      in_wr      = 1'b1;
      for (int i = 0; i < 3000; i++) begin
         @(negedge clk);
         if (in_rdy) begin
            ok = 1;
            break;
         end
      end
      if (!ok) begin
         checks++;
         errors++;
         $display("FAIL in_rdy_timeout: got in_rdy=0 expected 1 within 3000 cycles");
      end else begin
         model_word(sop, eop, c, d);
      end
      @(posedge clk);
      #1 in_wr = 1'b0;
   endtask

   task automatic send_pkt(input int len, input bit trunc);
      int idx = 0;
      int n;
      logic [DW-1:0] w;
      while (idx < len) begin
         n = $urandom_range(1, NB);
         if (n > len - idx) n = len - idx;
         w = rand_word();
         send_word(idx == 0, (idx + n == len) && !trunc, 6'(n), w);
         idx += n;
      end
   endtask

   task automatic wait_drain(input string name);
      bit ok = 0;
      for (int i = 0; i < 5000; i++) begin
         @(negedge clk);
         if (exp_q.size() == 0 && !out_valid && in_rdy) begin
            ok = 1;
            break;
         end
      end
      if (!ok) begin
         checks++;
         errors++;
         $display("FAIL %s_drain: got %0d bytes outstanding expected 0", name, exp_q.size());
      end
      @(posedge clk);
      #1;
   endtask

   task automatic model_reset();
      exp_q.delete();
      m_open = 0;
      m_err  = 0;
      m_pkts = 8'd0;
   endtask

   // Pause generator: 0 off, 1 toggles every 2 cycles, 2 random.
   initial begin
      int pc = 0;
      forever begin
         @(posedge clk);
         #1;
         pc++;
         case (pmode)
            1:       pause = pc[1];
            2:       pause = ($urandom_range(0, 3) == 0);
            default: pause = 1'b0;
         endcase
      end
   end

   // Monitor: pop on every consumed byte, and check outputs stay frozen under pause.
   logic       hold_chk = 0;
   logic [7:0] p_data;
   logic       p_valid, p_newpkt, p_eop;
   always @(negedge clk) begin
      exp_t e;
      cyc++;
      if (!rst) begin
         hold_chk = 0;
      end else begin
         if (hold_chk) begin
            chk("pause_data",   {24'd0, out_data}, {24'd0, p_data});
            chk("pause_valid",  {31'd0, out_valid}, {31'd0, p_valid});
            chk("pause_newpkt", {31'd0, out_newpkt}, {31'd0, p_newpkt});
            chk("pause_eop",    {31'd0, out_eop}, {31'd0, p_eop});
         end
         chk("flag_qual", {31'd0, out_valid | !(out_newpkt | out_eop)}, 32'd1);
         if (out_valid && !pause) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_byte: got 0x%0h expected no output", out_data);
            end else begin
               e = exp_q.pop_front();
               chk("byte_data",   {24'd0, out_data}, {24'd0, e.d});
               chk("byte_newpkt", {31'd0, out_newpkt}, {31'd0, e.sop});
               chk("byte_eop",    {31'd0, out_eop}, {31'd0, e.eop});
            end
            pops++;
            prev_pop_cyc = last_pop_cyc;
            last_pop_cyc = cyc;
         end
         hold_chk = out_valid && pause;
         p_data   = out_data;
         p_valid  = out_valid;
         p_newpkt = out_newpkt;
         p_eop    = out_eop;
      end
   end

   initial begin
      #800000;
      $display("FAIL global_timeout: got no finish expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      logic [DW-1:0] w;
      int base;
      bit ok;

      // Reset state
      #1;
      chk("rst_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_rdy",   {31'd0, in_rdy}, 32'd0);
      chk("rst_pkt",   {24'd0, pktcount}, 32'd0);
      chk("rst_err",   {31'd0, err}, 32'd0);
      repeat (3) @(posedge clk);
      #1 rst = 1'b1;
      @(negedge clk);
      chk("rdy_before_edge", {31'd0, in_rdy}, 32'd0);
      @(posedge clk);
      #1;
      chk("rdy_after_edge", {31'd0, in_rdy}, 32'd1);

      // 64-byte packet 0x00..0x3F as 60 + 4
      w = '0;
      for (int k = 0; k < NB; k++) w[DW-1-8*k -: 8] = 8'(k);
      send_word(1, 0, 6'd60, w);
      w = rand_word();
      for (int k = 0; k < 4; k++) w[DW-1-8*k -: 8] = 8'(60 + k);
      send_word(0, 1, 6'd4, w);
      wait_drain("pkt64");
      chk("pkt64_count", {24'd0, pktcount}, 32'd1);
      chk("pkt64_err",   {31'd0, err}, 32'd0);
      chk("pkt64_gapless", last_pop_cyc - prev_pop_cyc, 32'd1);

      // Back-to-back single-byte packets
      w = rand_word(); w[DW-1 -: 8] = 8'hAA;
      send_word(1, 1, 6'd1, w);
      w = rand_word(); w[DW-1 -: 8] = 8'hBB;
      send_word(1, 1, 6'd1, w);
      wait_drain("b2b");
      chk("b2b_gap",   last_pop_cyc - prev_pop_cyc, 32'd1);
      chk("b2b_count", {24'd0, pktcount}, {24'd0, m_pkts});

      // Pause toggled every 2 cycles; second word must park in hold
      pmode = 1;
      send_word(1, 1, 6'd60, rand_word());
      send_word(1, 1, 6'd60, rand_word());
      chk("hold_full_rdy", {31'd0, in_rdy}, 32'd0);
      wait_drain("pause");
      pmode = 0;
      chk("pause_count", {24'd0, pktcount}, {24'd0, m_pkts});
      chk("pause_err",   {31'd0, err}, 32'd0);

      // Non-SOP word in IDLE is dropped, then a 3-byte packet
      base = pops;
      send_word(0, 0, 6'd10, rand_word());
      w = rand_word();
      w[DW-1 -: 24] = 24'h112233;
      send_word(1, 1, 6'd3, w);
      wait_drain("drop");
      chk("drop_bytes", pops - base, 32'd3);
      chk("drop_err",   {31'd0, err}, 32'd1);
      chk("drop_count", {24'd0, pktcount}, {24'd0, m_pkts});

      // cnt=0 treated as a full word
      base = pops;
      send_word(1, 1, 6'd0, rand_word());
      wait_drain("cnt0");
      chk("cnt0_bytes", pops - base, 32'd60);
      chk("cnt0_err",   {31'd0, err}, {31'd0, m_err});

      // Reset mid-packet at byte 20
      base = pops;
      send_word(1, 1, 6'd60, rand_word());
      ok = 0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (pops - base >= 20) begin
            ok = 1;
            break;
         end
      end
      chk("mid_reached", {31'd0, ok}, 32'd1);
      #2 rst = 1'b0;
      #1;
      chk("mid_rst_valid",  {31'd0, out_valid}, 32'd0);
      chk("mid_rst_data",   {24'd0, out_data}, 32'd0);
      chk("mid_rst_flags",  {30'd0, out_newpkt, out_eop}, 32'd0);
      chk("mid_rst_rdy",    {31'd0, in_rdy}, 32'd0);
      chk("mid_rst_pkt",    {24'd0, pktcount}, 32'd0);
      chk("mid_rst_err",    {31'd0, err}, 32'd0);
      model_reset();
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk);
      #1;
      w = rand_word();
      w[DW-1 -: 16] = 16'hC3D4;
      send_word(1, 1, 6'd2, w);
      wait_drain("post_rst");
      chk("post_rst_count", {24'd0, pktcount}, 32'd1);
      chk("post_rst_err",   {31'd0, err}, 32'd0);

      // Random traffic with random pause; clean packets first
      pmode = 2;
      for (int p = 0; p < 12; p++) send_pkt($urandom_range(1, 130), 0);
      wait_drain("rand_clean");
      chk("rand_clean_count", {24'd0, pktcount}, {24'd0, m_pkts});
      chk("rand_clean_err",   {31'd0, err}, 32'd0);
      // Then some packets missing their EOP, forcing SOP-while-open
      for (int p = 0; p < 10; p++) send_pkt($urandom_range(1, 130), ($urandom_range(0, 3) == 0));
      send_pkt(5, 0);
      wait_drain("rand_mix");
      pmode = 0;
      chk("rand_mix_count", {24'd0, pktcount}, {24'd0, m_pkts});
      chk("rand_mix_err",   {31'd0, err}, {31'd0, m_err});

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
